vmem_req_seq: RTL and testbench

VMEM_REQ_SEQ -- requirements
Module: vmem_req_seq

---
 rtl/vmem_req_seq.sv | 166 ++++++++++++++++
 tb/tb_vmem_req_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_req_seq.sv
// vmem_req_seq: vector memory request sequencer.
// Turns one strided load/store command into per-beat requests to the memory
// queue. Loads issue one address per cycle and then count returned beats.
// Stores forward VRF beats as they arrive and then wait for the queue's
// final store acknowledgement.
// Optional feature macro VMEM_REQ_SEQ_STRIDE_EN: when defined, cmd_stride
// sets the byte stride. When undefined, the stride is fixed at DW_B (unit
// stride) and cmd_stride is ignored.
module vmem_req_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BEAT_BITS  = 9,
  parameter int DW_B       = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_store,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic [BEAT_BITS-1:0]  cmd_beats,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [DW_B-1:0]       st_be,
  input  logic                  st_valid,
  output logic                  st_ready,
  output logic [ADDR_WIDTH-1:0] q_addr,
  output logic                  q_req,
  output logic                  q_valid,
  output logic                  q_start,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic [DW_B-1:0]       q_be,
  output logic                  q_ready,
  input  logic [DATA_WIDTH-1:0] q_data_in,
  input  logic                  q_valid_in,
  input  logic                  q_done_st,
  input  logic                  ld_ready,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_ISSUE = 3'd1,
    LD_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [BEAT_BITS-1:0]  beats_q, beats_d;
  logic [BEAT_BITS-1:0]  beat_cnt_q, beat_cnt_d;
  logic [BEAT_BITS-1:0]  rx_cnt_q, rx_cnt_d;
  logic                  zero_q, zero_d;
  logic [DATA_WIDTH-1:0] ld_data_q;
  logic                  ld_valid_q;
  logic [ADDR_WIDTH-1:0] stride_sel;
  logic                  last_beat;
  logic                  rx_all;

`ifdef VMEM_REQ_SEQ_STRIDE_EN
  assign stride_sel = cmd_stride;
`else
  logic unused_stride;
  assign unused_stride = ^cmd_stride;
  assign stride_sel    = ADDR_WIDTH'(DW_B);
`endif

  assign last_beat = (beat_cnt_q == beats_q - BEAT_BITS'(1));
  assign rx_all    = (rx_cnt_q == beats_q);

  // State and datapath registers; ld_data/ld_valid are a plain 1-cycle delay
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      rx_cnt_q   <= '0;
      zero_q     <= 1'b0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      zero_q     <= zero_d;
      ld_data_q  <= q_data_in;
      ld_valid_q <= q_valid_in;
    end
  end

  // Next state; the beat address accumulates the stride instead of multiplying
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    zero_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_base;
          stride_d   = stride_sel;
          beats_d    = cmd_beats;
          beat_cnt_d = '0;
          rx_cnt_d   = '0;
          // An empty command never leaves IDLE; it only produces a done pulse
          if (cmd_beats == '0) zero_d = 1'b1;
          else                 state_d = cmd_store ? ST_ISSUE : LD_ISSUE;
        end
      end
      LD_ISSUE: begin
        addr_d     = addr_q + stride_q;
        beat_cnt_d = beat_cnt_q + BEAT_BITS'(1);
        if (q_valid_in) rx_cnt_d = rx_cnt_q + BEAT_BITS'(1);
        if (last_beat)  state_d = LD_WAIT;
      end
      LD_WAIT: begin
        if (rx_all)          state_d = IDLE;
        else if (q_valid_in) rx_cnt_d = rx_cnt_q + BEAT_BITS'(1);
      end
      ST_ISSUE: begin
        if (st_valid) begin
          addr_d     = addr_q + stride_q;
          beat_cnt_d = beat_cnt_q + BEAT_BITS'(1);
          if (last_beat) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (q_done_st) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; done merges the three completion sources
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    st_ready  = (state_q == ST_ISSUE);
    q_req     = (state_q == LD_ISSUE);
    q_valid   = (state_q == ST_ISSUE) && st_valid;
    q_start   = (beat_cnt_q == '0) && (q_req || q_valid);
    q_addr    = addr_q;
    q_data    = st_data;
    q_be      = st_be;
    q_ready   = ld_ready;
    ld_data   = ld_data_q;
    ld_valid  = ld_valid_q;
    done      = zero_q
              || ((state_q == LD_WAIT) && rx_all)
              || ((state_q == ST_WAIT) && q_done_st);
  end

endmodule

// File: tb/tb_vmem_req_seq.sv
// Directed bench for vmem_req_seq: load, store, empty command, address
// wrap and mid-command reset, checked against hand-computed values.
module tb_vmem_req_seq;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BB = 9;
  localparam int BW = DW/8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_store;
  logic [AW-1:0] cmd_base, cmd_stride;
  logic [BB-1:0] cmd_beats;
  logic [DW-1:0] st_data;
  logic [BW-1:0] st_be;
  logic          st_valid, st_ready;
  logic [AW-1:0] q_addr;
  logic          q_req, q_valid, q_start;
  logic [DW-1:0] q_data;
  logic [BW-1:0] q_be;
  logic          q_ready;
  logic [DW-1:0] q_data_in;
  logic          q_valid_in;
  logic          q_done_st, ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_valid, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  vmem_req_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_beats(cmd_beats),
    .st_data(st_data), .st_be(st_be), .st_valid(st_valid), .st_ready(st_ready),
    .q_addr(q_addr), .q_req(q_req), .q_valid(q_valid), .q_start(q_start),
    .q_data(q_data), .q_be(q_be), .q_ready(q_ready),
    .q_data_in(q_data_in), .q_valid_in(q_valid_in), .q_done_st(q_done_st),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_valid(ld_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Observation state filled at the falling edge
  int            cyc, acc_cyc, done_cyc;
  int            n_req, n_qv, n_start, n_ldv, n_done;
  logic [AW-1:0] req_addr [8];
  int            req_cyc  [8];
  logic [AW-1:0] qv_addr  [8];
  logic [DW-1:0] qv_data  [8];
  logic [BW-1:0] qv_be    [8];
  logic [AW-1:0] start_addr;
  logic [DW-1:0] last_ld;
  logic [2:0]    ret_pipe = '0;
  logic          auto_ret = 1'b1;

  // Memory model: each load request returns data three cycles later
  assign q_valid_in = ret_pipe[2];
  assign q_data_in  = 64'h1122_3344_5566_7788;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (q_req) begin
      if (n_req < 8) begin req_addr[n_req] = q_addr; req_cyc[n_req] = cyc; end
      n_req = n_req + 1;
    end
    if (q_valid) begin
      if (n_qv < 8) begin qv_addr[n_qv] = q_addr; qv_data[n_qv] = q_data; qv_be[n_qv] = q_be; end
      n_qv = n_qv + 1;
    end
    if (q_start) begin n_start = n_start + 1; start_addr = q_addr; end
    if (ld_valid) begin n_ldv = n_ldv + 1; last_ld = ld_data; end
    if (done) begin n_done = n_done + 1; done_cyc = cyc; end
    ret_pipe = {ret_pipe[1:0], q_req & auto_ret};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    n_req = 0; n_qv = 0; n_start = 0; n_ldv = 0; n_done = 0;
    acc_cyc = -1; done_cyc = -1;
  endtask

  task automatic issue(input logic st, input logic [AW-1:0] base,
                       input logic [AW-1:0] stride, input logic [BB-1:0] beats);
    cmd_valid = 1'b1; cmd_store = st; cmd_base = base;
    cmd_stride = stride; cmd_beats = beats;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && n_done == 0; i++) tick();
  endtask

  task automatic store_beat(input logic v, input logic [DW-1:0] d, input logic [BW-1:0] be);
    st_valid = v; st_data = d; st_be = be;
    tick();
  endtask

  initial begin
    cyc = 0;
    clr();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0;
    cmd_stride = '0; cmd_beats = '0; st_data = '0; st_be = '0; st_valid = 1'b0;
    q_done_st = 1'b0; ld_ready = 1'b0;
    tick(); tick(); tick();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_q_req", q_req, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q_start", q_start, 0);
    check("rst_ld_valid", ld_valid, 0);
    check("rst_done", done, 0);
    check("rst_st_ready", st_ready, 0);
    check("q_ready_lo", q_ready, 0);
    ld_ready = 1'b1; #1;
    check("q_ready_hi", q_ready, 1);
    rst_n = 1'b1;
    tick();

    // Load: base 0x1000, stride 8, 4 beats
    clr();
    issue(1'b0, 32'h1000, 32'd8, 9'd4);
    check("ld_busy", busy, 1);
    wait_done();
    tick(); tick(); tick();
    check("ld_nreq", n_req, 4);
    check("ld_a0", req_addr[0], 32'h1000);
    check("ld_a1", req_addr[1], 32'h1008);
    check("ld_a2", req_addr[2], 32'h1010);
    check("ld_a3", req_addr[3], 32'h1018);
    check("ld_first_lat", req_cyc[0] - acc_cyc, 1);
    check("ld_consec", req_cyc[3] - req_cyc[0], 3);
    check("ld_nstart", n_start, 1);
    check("ld_start_addr", start_addr, 32'h1000);
    check("ld_nldv", n_ldv, 4);
    check("ld_data", last_ld, 64'h1122_3344_5566_7788);
    check("ld_ndone", n_done, 1);
    check("ld_busy_after", busy, 0);

    // Store: 3 beats, st_valid 1,0,1,0,1
    clr();
    issue(1'b1, 32'h2000, 32'd8, 9'd3);
    check("st_ready_issue", st_ready, 1);
    store_beat(1'b1, 64'hAAAA_0000_0000_0001, 8'h0F);
    store_beat(1'b0, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
    store_beat(1'b1, 64'hAAAA_0000_0000_0002, 8'hF0);
    store_beat(1'b0, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
    store_beat(1'b1, 64'hAAAA_0000_0000_0003, 8'h3C);
    st_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("st_nqv", n_qv, 3);
    check("st_a1", qv_addr[1], 32'h2008);
    check("st_a2", qv_addr[2], 32'h2010);
    check("st_d2", qv_data[2], 64'hAAAA_0000_0000_0003);
    check("st_be1", qv_be[1], 8'hF0);
    check("st_nstart", n_start, 1);
    check("st_wait_ready", st_ready, 0);
    check("st_wait_busy", busy, 1);
    check("st_no_early_done", n_done, 0);
    q_done_st = 1'b1; tick(); q_done_st = 1'b0;
    tick();
    check("st_ndone", n_done, 1);
    check("st_busy_after", busy, 0);

    // Stray store ack while idle is ignored
    clr();
    q_done_st = 1'b1; tick(); q_done_st = 1'b0;
    tick(); tick();
    check("stray_ack_done", n_done, 0);

    // Empty command
    clr();
    issue(1'b0, 32'h5000, 32'd8, 9'd0);
    check("zero_busy", busy, 0);
    tick(); tick();
    check("zero_nreq", n_req + n_qv, 0);
    check("zero_ndone", n_done, 1);
    check("zero_done_lat", done_cyc - acc_cyc, 1);

    // Address wrap
    clr();
    issue(1'b0, 32'hFFFF_FFF8, 32'd16, 9'd2);
    wait_done();
    tick(); tick(); tick();
    check("wrap_nreq", n_req, 2);
    check("wrap_a0", req_addr[0], 32'hFFFF_FFF8);
`ifdef VMEM_REQ_SEQ_STRIDE_EN
    check("wrap_a1", req_addr[1], 32'h0000_0008);
`else
    check("wrap_a1", req_addr[1], 32'h0000_0000);
`endif

    // Reset while waiting for 2 outstanding load beats
    clr();
    auto_ret = 1'b0;
    issue(1'b0, 32'h3000, 32'd8, 9'd2);
    tick(); tick(); tick();
    check("rstmid_busy", busy, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rstmid_idle", cmd_ready, 1);
    check("rstmid_busy0", busy, 0);
    tick(); tick(); tick();
    check("rstmid_nodone", n_done, 0);
    clr();
    auto_ret = 1'b1;
    issue(1'b0, 32'h4000, 32'd8, 9'd1);
    wait_done();
    tick(); tick(); tick();
    check("after_nreq", n_req, 1);
    check("after_addr", req_addr[0], 32'h4000);
    check("after_nldv", n_ldv, 1);
    check("after_ndone", n_done, 1);
    check("after_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
